parity_accum_pipe: RTL and testbench
====================================

PARITY_ACCUM_PIPE -- requirements
Module: parity_accum_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per channel per beat.
REQ-002 SHALL have parameter CHANS, default 4, number of independent parity channels.
REQ-003 SHALL have parameter CNT_W, default 8, width of the error-frame counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port clr  input  1  synchronous clear: aborts the current frame and zeroes err_cnt.
REQ-007 SHALL have port mode  input  1  0 = even parity (XOR of bits), 1 = odd parity (inverted XOR).
REQ-008 SHALL have port in_valid  input  1  input beat valid.
REQ-009 SHALL have port in_ready  output  1  block accepts a beat.
REQ-010 SHALL have port in_data  input  CHANS*WIDTH  beat data; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-011 SHALL have port in_last  input  1  final beat of a frame.
REQ-012 SHALL have port exp_par  input  CHANS  expected per-channel frame parity, sampled only on the accepted last beat.
REQ-013 SHALL have port out_valid  output  1  frame result valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-015 SHALL have port out_par  output  CHANS  computed frame parity per channel.
REQ-016 SHALL have port out_err  output  CHANS  per-channel mismatch, out_par XOR the sampled exp_par.
REQ-017 SHALL have port err_cnt  output  CNT_W  count of frames with any out_err bit set.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACCUM and REPORT.
REQ-019 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in REPORT.
REQ-020 SHALL drive out_valid = 1 only in REPORT.
REQ-021 SHALL transfer an input beat exactly on a cycle with in_valid && in_ready.
REQ-022 SHALL update per-channel accumulator acc[c] ^= XOR-reduce(channel c slice) on each accepted beat without in_last.
- IDLE, beat accepted without in_last -> ACCUM.
- IDLE or ACCUM, beat accepted with in_last -> REPORT.
REQ-023 SHALL, on an accepted in_last beat, register out_par[c] = acc[c] ^ beat parity[c] ^ mode and out_err = out_par ^ exp_par.
REQ-024 SHALL assert out_valid on the cycle after the last beat is accepted (latency of 1 cycle).
REQ-025 SHALL hold out_par, out_err and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL ignore in_valid while in REPORT (no accumulation occurs).
REQ-027 SHALL, on out_valid && out_ready, move REPORT -> IDLE and clear acc to 0.
REQ-028 SHALL clear out_par and out_err on the same REPORT -> IDLE transition.
REQ-029 SHALL increment err_cnt by 1 on the cycle the REPORT result is registered if any out_err bit is 1.
REQ-030 SHALL saturate err_cnt at 2^CNT_W-1 and never wrap.
REQ-031 SHALL sample mode on every accepted beat, with the value on the last beat applied to the result.
REQ-032 SHALL give clr priority over every other event on a cycle: state -> IDLE, acc = 0, out_valid = 0, err_cnt = 0, and any beat on that cycle discarded.
REQ-033 SHALL NOT treat zero-length frames as frames: a result is produced only for an accepted last beat.

Reset
REQ-034 SHALL, while rst = 1, force state = IDLE, acc = 0, out_valid = 0, out_par = 0, out_err = 0 and err_cnt = 0 immediately, independent of clk.
REQ-035 SHALL hold in_ready = 1 during reset.
REQ-036 SHALL discard a partial frame on reset asserted mid-frame.
REQ-037 SHALL process the first beat after rst deassertion as the start of a new frame.

Verification (WIDTH=8, CHANS=4)
REQ-038 SHALL cover: rst pulse mid-operation -> out_valid=0, in_ready=1, err_cnt=0, out_par=4'b0000 asynchronously.
REQ-039 SHALL cover: single beat in_data=32'h010307FF, in_last=1, mode=0, exp_par=4'b0000 -> next cycle out_valid=1, out_par=4'b1010, out_err=4'b1010, err_cnt=1.
REQ-040 SHALL cover: two beats of 32'h010307FF (second with in_last), mode=1, exp_par=4'b1111 -> out_par=4'b1111, out_err=4'b0000, err_cnt unchanged.
REQ-041 SHALL cover: out_ready=0 for 5 cycles in REPORT with in_valid=1 -> out_valid held at 1, outputs stable, in_ready=0, no beats consumed; out_ready=1 -> IDLE next cycle.
REQ-042 SHALL cover: CNT_W=2, five consecutive frames with errors -> err_cnt=3 after all five; then clr=1 -> err_cnt=0, state IDLE.
REQ-043 SHALL cover: rst asserted after the first beat of a 3-beat frame, then a fresh single-beat frame 32'h00000001 with mode=0 -> out_par=4'b0001.

Source files
------------

// File: rtl/parity_accum_pipe.sv
// -----------------------------------------------------------------------------
// parity_accum_pipe
//
// Accumulates per-channel parity over a multi-beat frame and reports the
// result once the last beat arrives. The result is held until the consumer
// takes it. While a result is waiting, no new beats are accepted. A saturating
// counter records how many frames had at least one channel mismatch.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   clr        synchronous clear: aborts the frame and zeroes err_cnt
//   mode       0 = even parity, 1 = odd parity (value on the last beat wins)
//   in_valid   beat valid
//   in_ready   beat accepted when in_valid && in_ready
//   in_data    beat data, channel c at [c*WIDTH +: WIDTH]
//   in_last    final beat of a frame
//   exp_par    expected per-channel parity, sampled on the accepted last beat
//   out_valid  frame result valid
//   out_ready  consumer accepts the result
//   out_par    computed per-channel frame parity
//   out_err    out_par ^ sampled exp_par
//   err_cnt    saturating count of frames with any out_err bit set
// -----------------------------------------------------------------------------
module parity_accum_pipe #(
    parameter int WIDTH = 8,
    parameter int CHANS = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CHANS*WIDTH-1:0] in_data,
    input  logic                   in_last,
    input  logic [CHANS-1:0]       exp_par,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHANS-1:0]       out_par,
    output logic [CHANS-1:0]       out_err,
    output logic [CNT_W-1:0]       err_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [CHANS-1:0] acc;
    logic [CHANS-1:0] beat_par;
    logic [CHANS-1:0] frame_par;
    logic [CHANS-1:0] frame_err;
    logic             accept;

    // Both handshake outputs depend only on the state. This keeps them free of
    // combinational paths from the inputs. It also makes them take their reset
    // values as soon as rst rises.
    assign in_ready  = (state != S_REPORT);
    assign out_valid = (state == S_REPORT);
    assign accept    = in_valid && in_ready;

    // NOTE: every always_comb output gets a default before any conditional
    // logic, so no path can leave it unassigned and infer a latch.
    always_comb begin
        beat_par = '0;
        for (int c = 0; c < CHANS; c++) begin
            beat_par[c] = ^in_data[c*WIDTH +: WIDTH];
        end
    end

    // Odd parity is the even parity of the whole frame inverted. Only the mode
    // on the last beat matters, so the inversion happens here and not in acc.
    assign frame_par = acc ^ beat_par ^ {CHANS{mode}};
    assign frame_err = frame_par ^ exp_par;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            acc     <= '0;
            out_par <= '0;
            out_err <= '0;
            err_cnt <= '0;
        end else if (clr) begin
            // clr overrides everything, including a beat offered this cycle.
            state   <= S_IDLE;
            acc     <= '0;
            out_par <= '0;
            out_err <= '0;
            err_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            out_par <= frame_par;
                            out_err <= frame_err;
                            state   <= S_REPORT;
                            if ((|frame_err) && (err_cnt != CNT_MAX)) begin
                                err_cnt <= err_cnt + CNT_W'(1);
                            end
                        end else begin
                            acc   <= acc ^ beat_par;
                            state <= S_ACCUM;
                        end
                    end
                end
                S_REPORT: begin
                    // in_ready is low here, so offered beats are ignored.
                    if (out_ready) begin
                        state   <= S_IDLE;
                        acc     <= '0;
                        out_par <= '0;
                        out_err <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    acc   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_accum_pipe.sv
// -----------------------------------------------------------------------------
// tb_parity_accum_pipe
//
// Drives two instances with the same inputs: the default counter width and a
// 2-bit counter that shows saturation. A frame-level reference model predicts
// every output. A compare process checks both instances on each falling edge.
// Directed frames with hand-computed values pin the model. A long random run
// follows.
// -----------------------------------------------------------------------------
module tb_parity_accum_pipe;

    localparam int WIDTH = 8;
    localparam int CHANS = 4;
    localparam int DW    = CHANS * WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             mode = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    in_data = '0;
    logic [CHANS-1:0] exp_par = '0;

    logic             in_ready, out_valid;
    logic [CHANS-1:0] out_par, out_err;
    logic [7:0]       err_cnt;
    logic             in_ready2, out_valid2;
    logic [CHANS-1:0] out_par2, out_err2;
    logic [1:0]       err_cnt2;

    int n_cmp  = 0;
    int n_fail = 0;

    parity_accum_pipe #(.WIDTH(WIDTH), .CHANS(CHANS), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .exp_par(exp_par),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_par(out_par), .out_err(out_err), .err_cnt(err_cnt)
    );

    parity_accum_pipe #(.WIDTH(WIDTH), .CHANS(CHANS), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .clr(clr), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .in_last(in_last), .exp_par(exp_par),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_par(out_par2), .out_err(out_err2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model keeps the XOR of all data words seen in the frame. The parity
    // of that word per channel is the frame parity.
    bit               m_busy = 1'b0;
    logic [DW-1:0]    m_fx   = '0;
    logic [CHANS-1:0] m_par  = '0;
    logic [CHANS-1:0] m_err  = '0;
    int               m_cnt8 = 0;
    int               m_cnt2 = 0;

    function automatic logic [CHANS-1:0] chan_par(input logic [DW-1:0] v);
        logic [CHANS-1:0] r;
        r = '0;
        for (int c = 0; c < CHANS; c++) r[c] = ^v[c*WIDTH +: WIDTH];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0; m_fx = '0; m_par = '0; m_err = '0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (clr) begin
            m_busy = 1'b0; m_fx = '0; m_par = '0; m_err = '0; m_cnt8 = 0; m_cnt2 = 0;
        end else if (m_busy) begin
            if (out_ready) begin
                m_busy = 1'b0; m_par = '0; m_err = '0; m_fx = '0;
            end
        end else if (in_valid) begin
            if (in_last) begin
                m_par  = chan_par(m_fx ^ in_data) ^ {CHANS{mode}};
                m_err  = m_par ^ exp_par;
                m_busy = 1'b1;
                m_fx   = '0;
                if (m_err != '0) begin
                    if (m_cnt8 < 255) m_cnt8++;
                    if (m_cnt2 < 3)   m_cnt2++;
                end
            end else begin
                m_fx = m_fx ^ in_data;
            end
        end
    end

    always @(negedge clk) begin
        check("out_valid",  out_valid,  m_busy);
        check("in_ready",   in_ready,   !m_busy);
        check("out_par",    out_par,    m_par);
        check("out_err",    out_err,    m_err);
        check("err_cnt",    err_cnt,    m_cnt8);
        check("out_valid2", out_valid2, m_busy);
        check("in_ready2",  in_ready2,  !m_busy);
        check("out_par2",   out_par2,   m_par);
        check("out_err2",   out_err2,   m_err);
        check("err_cnt2",   err_cnt2,   m_cnt2);
    end

    // ---------------- stimulus helpers ----------------
    task automatic beat(input logic [DW-1:0] d, input logic last, input logic m,
                        input logic [CHANS-1:0] e);
        in_valid = 1'b1; in_data = d; in_last = last; mode = m; exp_par = e;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic async_reset(input bit do_check);
        #2 rst = 1'b1;
        #1;
        if (do_check) begin
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_in_ready",  in_ready,  1'b1);
            check("rst_err_cnt",   err_cnt,   8'd0);
            check("rst_out_par",   out_par,   4'b0000);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [DW-1:0] PAT = 32'h010307FF;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_in_ready",  in_ready,  1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_err_cnt",   err_cnt,   8'd0);
        rst = 1'b0;

        // Single-beat frame, even parity, all channels expected 0.
        beat(PAT, 1'b1, 1'b0, 4'b0000);
        check("single_valid",   out_valid, 1'b1);
        check("single_par",     out_par,   4'b1010);
        check("single_err",     out_err,   4'b1010);
        check("single_cnt",     err_cnt,   8'd1);
        take_result();
        check("single_cleared", out_par,   4'b0000);

        // Two identical beats cancel; odd mode gives all ones.
        beat(PAT, 1'b0, 1'b1, 4'b0000);
        check("two_mid_valid", out_valid, 1'b0);
        check("two_mid_ready", in_ready,  1'b1);
        beat(PAT, 1'b1, 1'b1, 4'b1111);
        check("two_par", out_par, 4'b1111);
        check("two_err", out_err, 4'b0000);
        check("two_cnt", err_cnt, 8'd1);
        take_result();

        // Backpressure: the result holds and offered beats are refused.
        beat(PAT, 1'b1, 1'b0, 4'b0000);
        in_valid = 1'b1; in_last = 1'b1; in_data = 32'hFFFF_FFFE;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1'b1);
            check("bp_ready", in_ready,  1'b0);
            check("bp_par",   out_par,   4'b1010);
            check("bp_cnt",   err_cnt,   8'd2);
        end
        in_valid = 1'b0; in_last = 1'b0;
        take_result();
        check("bp_idle_valid", out_valid, 1'b0);
        check("bp_idle_ready", in_ready,  1'b1);

        // Five more error frames: the 2-bit counter stops at 3.
        for (int i = 0; i < 5; i++) begin
            beat(PAT, 1'b1, 1'b0, 4'b0000);
            if (i < 4) take_result();
        end
        check("sat_cnt2", err_cnt2, 2'd3);
        check("sat_cnt8", err_cnt,  8'd7);
        // clr while a result is pending, with a last beat offered on the same cycle.
        clr = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_data = PAT;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("clr_cnt2",  err_cnt2,  2'd0);
        check("clr_cnt8",  err_cnt,   8'd0);
        check("clr_valid", out_valid, 1'b0);
        check("clr_ready", in_ready,  1'b1);
        @(negedge clk);
        check("clr_discard", out_valid, 1'b0);

        // Asynchronous reset while a result is pending.
        beat(PAT, 1'b1, 1'b0, 4'b0000);
        check("pre_rst_valid", out_valid, 1'b1);
        async_reset(1'b1);

        // Reset mid-frame, then a fresh single-beat frame.
        beat(PAT, 1'b0, 1'b0, 4'b0000);
        async_reset(1'b0);
        beat(32'h0000_0001, 1'b1, 1'b0, 4'b0000);
        check("fresh_par", out_par, 4'b0001);
        check("fresh_err", out_err, 4'b0001);
        take_result();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_last   = ($urandom_range(0, 3) == 0);
            mode      = 1'($urandom_range(0, 1));
            exp_par   = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 6);
            clr       = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
